f32_mult_issue: RTL and testbench

//  Operand-issue front end for the f32_mult sequential FP32 multiplier. Buffers (a,b) pairs from a

---
 rtl/f32_mult_issue.sv | 149 ++++++++++++++
 tb/tb_f32_mult_issue.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f32_mult_issue.sv
// Operand-issue front end for the sequential FP32 multiplier: an operand FIFO feeds a
// start/done handshake FSM whose results leave on a valid/ready stream, guarded by a watchdog.
module f32_mult_issue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_a,
    input  logic [31:0]            in_b,
    output logic [31:0]            mul_a,
    output logic [31:0]            mul_b,
    output logic                   mul_start,
    input  logic                   mul_done,
    input  logic [31:0]            mul_p,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_p,
    output logic                   out_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [31:0]   QNAN    = 32'h7FC0_0000;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_N  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

    state_t        r_state;
    logic [WW-1:0] r_wd;
    logic [31:0]   r_mem_a [DEPTH];
    logic [31:0]   r_mem_b [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_mul_a;
    logic [31:0]   r_mul_b;
    logic          r_mul_start;
    logic          r_out_valid;
    logic [31:0]   r_out_p;
    logic          r_out_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_N);
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    // A pop feeds the FSM directly: from IDLE, or when the pending result is taken in OUT.
    assign w_pop   = !w_empty && ((r_state == S_IDLE) || ((r_state == S_OUT) && out_ready));

    assign in_ready   = !w_full;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign fifo_count = r_count;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_start  = r_mul_start;
    assign out_valid  = r_out_valid;
    assign out_p      = r_out_p;
    assign out_err    = r_out_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wptr] <= in_a;
            r_mem_b[r_wptr] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wd        <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_mul_start <= 1'b0;
            if (w_pop) begin
                r_mul_a <= r_mem_a[r_rptr];
                r_mul_b <= r_mem_b[r_rptr];
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state     <= S_START;
                        r_mul_start <= 1'b1;
                    end
                end
                // mul_done is deliberately not looked at here: it may still be high from the last op.
                S_START: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        r_out_p     <= mul_p;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else if (r_wd >= WD_LAST) begin
                        r_out_p     <= QNAN;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (!w_empty) begin
                            r_state     <= S_START;
                            r_mul_start <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_f32_mult_issue.sv
// Bench for f32_mult_issue: a behavioural multiplier model plus a result scoreboard queue.
module tb_f32_mult_issue;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] mul_a, mul_b, mul_p;
    logic        mul_start, mul_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_p;
    logic        out_err;
    logic        busy;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];

    // multiplier model knobs and state
    int          mdl_delay = 5;
    bit          mdl_hang = 0;
    bit          mdl_level = 1;
    bit          force_done = 0;
    logic        mdl_done = 1'b0;
    logic [31:0] mdl_p = '0;
    logic [31:0] mdl_a = '0;
    logic [31:0] mdl_b = '0;
    int          mdl_cnt = 0;
    bit          mdl_busy = 0;
    bit          mdl_op_hang = 0;
    bit          stab_err = 0;
    bit          overlap_err = 0;
    int          start_cnt = 0;

    assign mul_done = mdl_done | force_done;
    assign mul_p    = mdl_p;

    f32_mult_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_done(mul_done), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_err(out_err),
        .busy(busy), .fifo_count(fifo_count)
    );

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40000000;
            64'h3F800000_3F800000: return 32'h3F800000;
            64'h40400000_C0000000: return 32'hC0C00000;
            64'hC1200000_41200000: return 32'hC2C80000;
            64'h40000000_40400000: return 32'h40C00000;
            64'h3F000000_41000000: return 32'h40800000;
            64'h40A00000_40A00000: return 32'h41C80000;
            default:               return a ^ {b[15:0], b[31:16]} ^ 32'h01234567;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mdl_done <= 1'b0;
            mdl_busy <= 0;
        end else if (mul_start) begin
            if (mdl_busy && !mdl_op_hang) overlap_err <= 1;
            start_cnt   <= start_cnt + 1;
            mdl_a       <= mul_a;
            mdl_b       <= mul_b;
            mdl_busy    <= 1;
            mdl_op_hang <= mdl_hang;
            mdl_cnt     <= mdl_delay;
            mdl_done    <= 1'b0;
        end else begin
            if (mdl_busy && (mul_a !== mdl_a || mul_b !== mdl_b)) stab_err <= 1;
            if (mdl_busy && !mdl_op_hang) begin
                if (mdl_cnt <= 1) begin
                    mdl_done <= 1'b1;
                    mdl_p    <= ref_mul(mdl_a, mdl_b);
                    mdl_busy <= 0;
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end else if (!mdl_level) begin
                mdl_done <= 1'b0;
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input bit abort);
        int n;
        in_a = a; in_b = b; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL push_ready in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        exp_q.push_back(abort ? {1'b1, QNAN} : {1'b0, ref_mul(a, b)});
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mul_start, out_valid, out_err, busy} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl start=%b valid=%b err=%b busy=%b expected all 0", mul_start, out_valid, out_err, busy);
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_count fifo_count=%0d expected 0", fifo_count);
        end
        checks++;
        if ({mul_a, mul_b, out_p} !== 96'b0) begin
            failures++;
            $display("FAIL reset_data mul_a=%h mul_b=%h out_p=%h expected 0", mul_a, mul_b, out_p);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b busy=%b expected 1/0", in_ready, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [32:0] e;
        int n, s0;
        mdl_level = 0; mdl_delay = 5; out_ready = 1'b1;
        s0 = start_cnt;
        in_a = 32'h3F800000; in_b = 32'h40000000; in_valid = 1'b1;
        exp_q.push_back({1'b0, 32'h40000000});
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mul_start !== 1'b0 || fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL t1_queued mul_start=%b fifo_count=%0d expected 0/1", mul_start, fifo_count);
        end
        @(negedge clk);
        checks++;
        if (mul_start !== 1'b1 || mul_a !== 32'h3F800000 || mul_b !== 32'h40000000) begin
            failures++;
            $display("FAIL t1_start mul_start=%b a=%h b=%h expected 1/3f800000/40000000", mul_start, mul_a, mul_b);
        end
        n = 0;
        while (mul_done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (mul_done !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL t1_done mul_done=%b out_valid=%b expected 1/0", mul_done, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL t1_latency out_valid=%b expected 1", out_valid);
        end
        e = exp_q.pop_front();
        checks++;
        if ({out_err, out_p} !== e) begin
            failures++;
            $display("FAIL t1_result err=%b p=%h expected err=%b p=%h", out_err, out_p, e[32], e[31:0]);
        end
        checks++;
        if (start_cnt - s0 != 1 || stab_err) begin
            failures++;
            $display("FAIL t1_pulse starts=%0d stab_err=%0d expected 1/0", start_cnt - s0, stab_err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t1_idle out_valid=%b busy=%b expected 0/0", out_valid, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        mdl_level = 1; mdl_delay = 3; out_ready = 1'b0;
        push(32'h3F800000, 32'h3F800000, 0);
        push(32'h40400000, 32'hC0000000, 0);
        push(32'h12345678, 32'h0BADF00D, 0);
        push(32'hDEADBEEF, 32'h00C0FFEE, 0);
        push(32'hC1200000, 32'h41200000, 0);
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL t2_full fifo_count=%0d in_ready=%b expected 4/0", fifo_count, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [32:0] e;
        int s0;
        bit bad, got;
        got = 0;
        for (int n = 0; n < 100 && !got; n++) begin @(negedge clk); got = (out_valid === 1'b1); end
        checks++;
        if (!got) begin failures++; $display("FAIL t3_first_valid out_valid=%b expected 1", out_valid); end
        held = out_p; s0 = start_cnt; bad = 0;
        in_a = 32'h55555555; in_b = 32'hAAAAAAAA; in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_p !== held || fifo_count !== 3'd4 || mul_start !== 1'b0) bad = 1;
        end
        checks++;
        if (bad || start_cnt != s0) begin
            failures++;
            $display("FAIL t3_hold out_valid=%b out_p=%h count=%0d new_starts=%0d expected 1/%h/4/0", out_valid, out_p, fifo_count, start_cnt - s0, held);
        end
        e = exp_q.pop_front();
        checks++;
        if ({out_err, out_p} !== e) begin
            failures++;
            $display("FAIL t3_first_result err=%b p=%h expected err=%b p=%h", out_err, out_p, e[32], e[31:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd3 || in_ready !== 1'b1 || mul_start !== 1'b1 || mul_a !== 32'h40400000) begin
            failures++;
            $display("FAIL t3_full_pop count=%0d in_ready=%b start=%b mul_a=%h expected 3/1/1/40400000", fifo_count, in_ready, mul_start, mul_a);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int n = 0; n < 100 && !got; n++) begin @(negedge clk); got = (out_valid === 1'b1); end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL t3_drain_timeout idx=%0d out_valid=0 expected 1", k);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL t3_drain_extra p=%h expected no result", out_p);
            end else begin
                e = exp_q.pop_front();
                if ({out_err, out_p} !== e) begin
                    failures++;
                    $display("FAIL t3_drain idx=%0d err=%b p=%h expected err=%b p=%h", k, out_err, out_p, e[32], e[31:0]);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL t3_leftover pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        logic [32:0] e;
        int lat;
        bit got;
        mdl_hang = 1; mdl_level = 1; mdl_delay = 3; out_ready = 1'b1;
        push(32'h3FC00000, 32'h40800000, 1);
        push(32'h40A00000, 32'h40A00000, 0);
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin @(negedge clk); got = (mul_start === 1'b1); end
        checks++;
        if (!got) begin failures++; $display("FAIL t4_start mul_start=0 expected 1"); end
        @(posedge clk); #1 mdl_hang = 0;
        lat = 0; got = 0;
        for (int n = 1; n <= 60 && !got; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin got = 1; lat = n; end
        end
        // START cycle, then TIMEOUT wait cycles, then the OUT cycle
        checks++;
        if (lat != TIMEOUT + 1) begin
            failures++;
            $display("FAIL t4_latency cycles=%0d expected %0d", lat, TIMEOUT + 1);
        end
        e = exp_q.pop_front();
        checks++;
        if ({out_err, out_p} !== e) begin
            failures++;
            $display("FAIL t4_abort err=%b p=%h expected err=%b p=%h", out_err, out_p, e[32], e[31:0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (mul_start !== 1'b1 || mul_a !== 32'h40A00000 || mul_b !== 32'h40A00000) begin
            failures++;
            $display("FAIL t4_next_issue start=%b a=%h b=%h expected 1/40a00000/40a00000", mul_start, mul_a, mul_b);
        end
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin @(negedge clk); got = (out_valid === 1'b1); end
        e = exp_q.pop_front();
        checks++;
        if (!got || {out_err, out_p} !== e) begin
            failures++;
            $display("FAIL t4_next_result valid=%b err=%b p=%h expected 1 err=%b p=%h", out_valid, out_err, out_p, e[32], e[31:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stale_done();
        logic [32:0] e;
        bit got;
        mdl_level = 1; mdl_delay = 2; out_ready = 1'b1;
        push(32'h40000000, 32'h40400000, 0);
        push(32'h3F000000, 32'h41000000, 0);
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin @(negedge clk); got = (out_valid === 1'b1); end
        e = exp_q.pop_front();
        checks++;
        if (!got || {out_err, out_p} !== e) begin
            failures++;
            $display("FAIL t5_first valid=%b err=%b p=%h expected 1 err=%b p=%h", out_valid, out_err, out_p, e[32], e[31:0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (mul_start !== 1'b1 || mul_done !== 1'b1) begin
            failures++;
            $display("FAIL t5_stale_window start=%b done=%b expected 1/1", mul_start, mul_done);
        end
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin @(negedge clk); got = (out_valid === 1'b1); end
        e = exp_q.pop_front();
        checks++;
        if (!got || {out_err, out_p} !== e) begin
            failures++;
            $display("FAIL t5_second valid=%b err=%b p=%h expected 1 err=%b p=%h", out_valid, out_err, out_p, e[32], e[31:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        int s0;
        bit bad;
        mdl_level = 0; mdl_delay = 30; out_ready = 1'b1;
        push(32'h11111111, 32'h22222222, 0);
        push(32'h33333333, 32'h44444444, 0);
        push(32'h55555555, 32'h66666666, 0);
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd2 || busy !== 1'b1 || mul_start !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL t6_wait count=%0d busy=%b start=%b valid=%b expected 2/1/0/0", fifo_count, busy, mul_start, out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0 || mul_start !== 1'b0) begin
            failures++;
            $display("FAIL t6_after_reset count=%0d valid=%b busy=%b start=%b expected 0/0/0/0", fifo_count, out_valid, busy, mul_start);
        end
        exp_q.delete();
        s0 = start_cnt;
        force_done = 1;
        repeat (3) @(posedge clk);
        #1 force_done = 0;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || mul_start !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad || start_cnt != s0) begin
            failures++;
            $display("FAIL t6_late_done valid=%b busy=%b new_starts=%0d expected 0/0/0", out_valid, busy, start_cnt - s0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_stale_done();
        test_reset_midop();
        checks++;
        if (stab_err || overlap_err) begin
            failures++;
            $display("FAIL model_protocol operand_change=%0d overlap=%0d expected 0/0", stab_err, overlap_err);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t expected completion", $time);
        $fatal(1, "timeout");
    end
endmodule
